// File: rtl/qvalue_max_scanner_if.sv
// Request/bank/result bundle between the Q-value max scanner and its neighbours.
// The slave side is the scanner. The master side is the decision logic plus the bank read port.
interface qvalue_max_scanner_if #(
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int SLOT_W     = 5
);
  logic                  start;
  logic [5:0]            num_slots;
  logic [ADDR_WIDTH-1:0] mem_index;
  logic [WORD_WIDTH-1:0] mem_data;
  logic                  busy;
  logic                  done;
  logic                  found;
  logic [WORD_WIDTH-1:0] best_q;
  logic [SLOT_W-1:0]     best_slot;

  modport slave (
    input  start, num_slots, mem_data,
    output mem_index, busy, done, found, best_q, best_slot
  );

  modport master (
    output start, num_slots, mem_data,
    input  mem_index, busy, done, found, best_q, best_slot
  );
endinterface

// File: rtl/qvalue_max_scanner.sv
// Walks N big-endian 16-bit Q-value slots of the cluster-head bank and reports
// the largest non-zero value (first occurrence on ties) with its slot number.
module qvalue_max_scanner #(
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int MAX_SLOTS  = 32
) (
  input logic                 clk,
  input logic                 nrst,
  qvalue_max_scanner_if.slave bus
);
  localparam int SLOT_W = $clog2(MAX_SLOTS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIN  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [5:0]            count_q, count_d;
  logic [SLOT_W-1:0]     k_q, k_d;
  logic [ADDR_WIDTH-1:0] mem_index_q, mem_index_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  found_q, found_d;
  logic [WORD_WIDTH-1:0] best_q_q, best_q_d;
  logic [SLOT_W-1:0]     best_slot_q, best_slot_d;
  logic [5:0]            count_clamp_s;

  // Next-state and next-output computation for the scan FSM
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    k_d           = k_q;
    mem_index_d   = mem_index_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    found_d       = found_q;
    best_q_d      = best_q_q;
    best_slot_d   = best_slot_q;
    count_clamp_s = (bus.num_slots > 6'(MAX_SLOTS)) ? 6'(MAX_SLOTS) : bus.num_slots;

    case (state_q)
      IDLE: begin
        mem_index_d = '0;
        busy_d      = 1'b0;
        if (bus.start) begin
          count_d     = count_clamp_s;
          k_d         = '0;
          best_q_d    = '0;
          best_slot_d = '0;
          found_d     = 1'b0;
          if (count_clamp_s == 6'd0) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            state_d = SCAN;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        // Strictly-greater replacement keeps the lowest-index slot on ties.
        if ((bus.mem_data != '0) && (bus.mem_data > best_q_q)) begin
          best_q_d    = bus.mem_data;
          best_slot_d = k_q;
          found_d     = 1'b1;
        end else begin
          best_q_d    = best_q_q;
          best_slot_d = best_slot_q;
          found_d     = found_q;
        end
        if (6'(k_q) == (count_q - 6'd1)) begin
          state_d     = FIN;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          mem_index_d = '0;
        end else begin
          state_d     = SCAN;
          k_d         = k_q + SLOT_W'(1);
          mem_index_d = ADDR_WIDTH'({k_q + SLOT_W'(1), 1'b0});
        end
      end
      FIN: begin
        state_d     = IDLE;
        busy_d      = 1'b0;
        mem_index_d = '0;
      end
      default: begin
        state_d     = IDLE;
        busy_d      = 1'b0;
        mem_index_d = '0;
      end
    endcase
  end

  // State and registered outputs, cleared asynchronously by nrst
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      count_q     <= 6'd0;
      k_q         <= '0;
      mem_index_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
      best_q_q    <= '0;
      best_slot_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      k_q         <= k_d;
      mem_index_q <= mem_index_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      found_q     <= found_d;
      best_q_q    <= best_q_d;
      best_slot_q <= best_slot_d;
    end
  end

  assign bus.mem_index = mem_index_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.found     = found_q;
  assign bus.best_q    = best_q_q;
  assign bus.best_slot = best_slot_q;
endmodule

// File: tb/tb_qvalue_max_scanner.sv
// Scoreboard bench for qvalue_max_scanner: a stimulus process queues expected
// results from a max/first-index reference model; a negedge monitor checks them.
module tb_qvalue_max_scanner;
  logic clk;
  logic nrst;
  logic [7:0] bank [64];
  longint cyc;
  int n_cmp;
  int n_bad;

  typedef struct {
    logic        found;
    logic [15:0] q;
    logic [4:0]  slot;
    longint      t_done;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   bc;

  qvalue_max_scanner_if bus_if ();

  qvalue_max_scanner dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus_if)
  );

  assign bus_if.mem_data = {bank[bus_if.mem_index], bank[bus_if.mem_index | 6'd1]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [15:0] word_at(int s);
    return {bank[2*s], bank[2*s+1]};
  endfunction

  task automatic set_word(int s, logic [15:0] w);
    bank[2*s]   = w[15:8];
    bank[2*s+1] = w[7:0];
  endtask

  // Reference: maximum of the scanned words, then the first slot holding it.
  function automatic exp_t model(int n);
    exp_t e;
    int cnt;
    logic [15:0] mx;
    cnt = (n > 32) ? 32 : n;
    mx = 16'h0000;
    for (int s = 0; s < cnt; s++) if (word_at(s) > mx) mx = word_at(s);
    e.found = (mx != 16'h0000);
    e.q = mx;
    e.slot = 5'd0;
    if (e.found) begin
      for (int s = cnt - 1; s >= 0; s--) if (word_at(s) == mx) e.slot = 5'(s);
    end
    e.t_done = 0;
    return e;
  endfunction

  // Monitor: reset values, address walk, result hold and done-time checks
  always @(negedge clk) begin
    if (!nrst) begin
      bc = 0;
      check("rst_busy", 32'(bus_if.busy), 32'd0);
      check("rst_done", 32'(bus_if.done), 32'd0);
      check("rst_found", 32'(bus_if.found), 32'd0);
      check("rst_best_q", 32'(bus_if.best_q), 32'd0);
      check("rst_best_slot", 32'(bus_if.best_slot), 32'd0);
      check("rst_mem_index", 32'(bus_if.mem_index), 32'd0);
    end else begin
      if (bus_if.busy) begin
        check("scan_mem_index", 32'(bus_if.mem_index), 32'(2 * bc));
        bc++;
      end else begin
        check("idle_mem_index", 32'(bus_if.mem_index), 32'd0);
      end
      if (bus_if.done) begin
        check("done_expected", 32'(sb.size() != 0), 32'd1);
        check("done_busy_low", 32'(bus_if.busy), 32'd0);
        if (sb.size() != 0) begin
          last = sb.pop_front();
          check("done_cycle", 32'(cyc), 32'(last.t_done));
          check("found", 32'(bus_if.found), 32'(last.found));
          check("best_q", 32'(bus_if.best_q), 32'(last.q));
          check("best_slot", 32'(bus_if.best_slot), 32'(last.slot));
        end
        bc = 0;
      end else if (!bus_if.busy) begin
        check("hold_found", 32'(bus_if.found), 32'(last.found));
        check("hold_best_q", 32'(bus_if.best_q), 32'(last.q));
        check("hold_best_slot", 32'(bus_if.best_slot), 32'(last.slot));
      end
    end
  end

  task automatic wait_result();
    int i;
    i = 0;
    while (sb.size() != 0 && i < 100) begin
      @(posedge clk);
      i++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done expected done within 100 cycles");
      sb.delete();
    end
  endtask

  task automatic issue_start(int n);
    exp_t e;
    e = model(n);
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.num_slots = 6'(n);
    @(posedge clk);
    #1;
    e.t_done = cyc + ((n > 32) ? 32 : n);
    sb.push_back(e);
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.num_slots = 6'($urandom);
  endtask

  task automatic run_scan(int n, bit mid_start);
    issue_start(n);
    if (mid_start) begin
      repeat (2) @(negedge clk);
      bus_if.start = 1'b1;
      bus_if.num_slots = 6'd2;
      @(negedge clk);
      bus_if.start = 1'b0;
    end
    wait_result();
  endtask

  task automatic fill_random();
    logic [15:0] w;
    for (int s = 0; s < 32; s++) begin
      case ($urandom_range(0, 3))
        0: w = 16'h0000;
        1: w = 16'($urandom_range(1, 4));
        default: w = 16'($urandom);
      endcase
      set_word(s, w);
    end
  endtask

  initial begin
    int wi;
    cyc = 0;
    n_cmp = 0;
    n_bad = 0;
    bc = 0;
    last = '{1'b0, 16'h0000, 5'd0, 0};
    nrst = 1'b0;
    bus_if.start = 1'b0;
    bus_if.num_slots = 6'd0;
    for (int i = 0; i < 64; i++) bank[i] = 8'($urandom);

    // Reset with random start and bank activity
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus_if.start = 1'($urandom);
      bus_if.num_slots = 6'($urandom);
      bank[$urandom_range(0, 63)] = 8'($urandom);
    end
    @(negedge clk);
    bus_if.start = 1'b0;
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle_busy", 32'(bus_if.busy), 32'd0);

    // Basic max
    for (int i = 0; i < 64; i++) bank[i] = 8'h00;
    set_word(0, 16'h0010); set_word(1, 16'h0300); set_word(2, 16'h0200); set_word(3, 16'h0050);
    run_scan(4, 1'b0);

    // Tie and empty slots
    set_word(0, 16'h0000); set_word(1, 16'h0400); set_word(2, 16'h0400); set_word(3, 16'h0000);
    run_scan(4, 1'b0);
    for (int i = 0; i < 64; i++) bank[i] = 8'h00;
    run_scan(8, 1'b0);

    // Boundaries: zero count, clamp, full-scale word in the last slot
    fill_random();
    run_scan(0, 1'b0);
    run_scan(40, 1'b0);
    for (int s = 0; s < 31; s++) set_word(s, 16'($urandom_range(1, 16'hFFFE)));
    set_word(31, 16'hFFFF);
    run_scan(32, 1'b0);

    // Start while busy is ignored
    fill_random();
    run_scan(10, 1'b1);

    // Async reset mid-scan, then a fresh scan
    fill_random();
    issue_start(16);
    wi = 0;
    while (!(bus_if.busy && bus_if.mem_index == 6'd10) && wi < 50) begin
      @(negedge clk);
      wi++;
    end
    check("reached_slot5", 32'(bus_if.mem_index), 32'd10);
    #2;
    nrst = 1'b0;
    #1;
    sb.delete();
    last = '{1'b0, 16'h0000, 5'd0, 0};
    check("abort_busy", 32'(bus_if.busy), 32'd0);
    check("abort_found", 32'(bus_if.found), 32'd0);
    check("abort_best_q", 32'(bus_if.best_q), 32'd0);
    check("abort_mem_index", 32'(bus_if.mem_index), 32'd0);
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    fill_random();
    run_scan(16, 1'b0);

    // Randomized scans
    for (int r = 0; r < 30; r++) begin
      fill_random();
      run_scan($urandom_range(0, 63), 1'($urandom_range(0, 1)) && 1'b0);
    end
    for (int r = 0; r < 6; r++) begin
      fill_random();
      run_scan($urandom_range(8, 40), 1'b1);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
